impostor_lsu: RTL
=================

IMPOSTOR_LSU -- requirements
Module: impostor_lsu

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of each event counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  1  pipeline presents a memory request.
REQ-005 SHALL have port: req_ready  output  1  LSU accepts a request this cycle.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_size  input  3  size code: 001 byte signed, 010 half signed, 011 word, 101 byte unsigned, 110 half unsigned.
REQ-008 SHALL have port: req_addr / req_wdata  input  32 each  byte address / store data.
REQ-009 SHALL have port: mem_addr / mem_write_data  output  32 each  to data memory.
REQ-010 SHALL have port: mem_read / mem_write  output  1 each  data-memory strobes.
REQ-011 SHALL have port: mem_size  output  3  size code to data memory.
REQ-012 SHALL have port: mem_read_data  input  32  data-memory read result, registered inside memory, valid after the strobe edge.
REQ-013 SHALL have port: resp_valid / resp_ready  output / input  1 each  response handshake.
REQ-014 SHALL have port: resp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 SHALL have port: resp_err / resp_is_load  output  1 each  illegal request flag / response belongs to a load.
REQ-016 SHALL have port: load_cnt, store_cnt, err_cnt  output  CNT_W each  completed-transaction counters.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge where IDLE and req_valid = 1, latching we, size, addr, wdata.
REQ-019 SHALL classify as illegal: size in {000,100,111}; store with size 101 or 110; half size with addr[0] = 1; word size with addr[1:0] != 00.
REQ-020 SHALL, for a legal request, go IDLE -> ACCESS; for an illegal one go IDLE -> RESP with resp_err = 1 and no memory strobe ever asserted.
REQ-021 SHALL, in ACCESS only, drive mem_addr, mem_write_data, mem_size from latched values and assert exactly one of mem_read (load) or mem_write (store) for exactly one cycle; then go to RESP.
REQ-022 SHALL hold mem_read = mem_write = 0 in IDLE and RESP; mem_addr/mem_write_data/mem_size hold last latched values outside ACCESS.
REQ-023 SHALL, in RESP, assert resp_valid; resp_rdata = mem_read_data for legal loads, else 0; resp_err and resp_is_load reflect the latched request.
REQ-024 SHALL hold all resp_* stable while resp_valid = 1 and resp_ready = 0; leave RESP to IDLE on the edge where resp_ready = 1.
REQ-025 SHALL yield latency: request accepted at edge E0 -> memory strobe cycle E0..E1 -> resp_valid from E1 (legal); resp_valid from E0 (illegal).
REQ-026 SHALL not accept a new request in the cycle a response completes (req_ready follows state, not resp_ready); back-to-back legal requests take 3 cycles minimum each.
REQ-027 SHALL increment on response completion (RESP with resp_ready = 1): err_cnt if resp_err, else load_cnt or store_cnt; counters wrap from all-ones to 0.
REQ-028 SHALL ignore req_valid, req_* changes while not in IDLE.

Reset
REQ-029 SHALL, while rst_n = 0, immediately force state IDLE, req_ready = 1 after release, resp_valid = 0, mem_read = mem_write = 0, mem_addr = mem_write_data = 0, mem_size = 000, resp_rdata = 0, resp_err = resp_is_load = 0, all counters 0.
REQ-030 SHALL, on reset asserted during ACCESS or RESP, abandon the transaction with no response and no counter update.

Verification
REQ-031 SHALL pass: store size 011 addr 0x8 data 0xDEADBEEF, then load size 011 addr 0x8 -> one-cycle mem_write, then resp_rdata = 0xDEADBEEF, resp_err = 0, store_cnt = 1, load_cnt = 1.
REQ-032 SHALL pass: word 0x000000F0 stored, load size 001 -> resp_rdata 0xFFFFFFF0; load size 101 -> 0x000000F0.
REQ-033 SHALL pass: load size 010 addr 0x3 -> resp_valid one edge after acceptance, resp_err = 1, mem_read never asserted, err_cnt = 1.
REQ-034 SHALL pass: resp_ready held 0 for 5 cycles in RESP -> resp_* stable, req_ready = 0, no extra strobes, counter increments once.
REQ-035 SHALL pass: rst_n driven low mid-ACCESS -> mem_write drops same cycle, resp_valid = 0, counters 0, next request served normally.
REQ-036 SHALL pass: store size 110 -> resp_err = 1, no mem_write; load_cnt forced to wrap after 2^CNT_W loads -> reads 0.

Source files
------------

// File: rtl/impostor_lsu.sv
// Single-outstanding load/store unit: accepts one request, validates it,
// issues one memory strobe for legal requests and returns one response.
module impostor_lsu #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_size,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    output logic             mem_read,
    output logic             mem_write,
    output logic [2:0]       mem_size,
    input  logic [31:0]      mem_read_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             resp_is_load,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    size_q, size_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             is_load_q, is_load_d;
    logic             ready_q, ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             rdata_sel_q, rdata_sel_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] store_cnt_q, store_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             req_illegal;

    // Flag unsupported size codes, stores with unsigned sizes and misaligned accesses
    always_comb begin
        req_illegal = 1'b0;
        unique case (req_size)
            3'b001:  req_illegal = 1'b0;
            3'b101:  req_illegal = req_we;
            3'b010:  req_illegal = req_addr[0];
            3'b110:  req_illegal = req_we | req_addr[0];
            3'b011:  req_illegal = (req_addr[1:0] != 2'b00);
            default: req_illegal = 1'b1;
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        is_load_d   = is_load_q;
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d    = req_size;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    err_d     = req_illegal;
                    is_load_d = ~req_we;
                    state_d   = req_illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    if (err_q) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end else if (is_load_q) begin
                        load_cnt_d = load_cnt_q + CNT_W'(1);
                    end else begin
                        store_cnt_d = store_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        mem_read_d   = (state_d == ACCESS) &&  is_load_d;
        mem_write_d  = (state_d == ACCESS) && !is_load_d;
        rdata_sel_d  = (state_d == RESP) && is_load_d && !err_d;
    end

    // State and output registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            is_load_q    <= 1'b0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rdata_sel_q  <= 1'b0;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            is_load_q    <= is_load_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            rdata_sel_q  <= rdata_sel_d;
            load_cnt_q   <= load_cnt_d;
            store_cnt_q  <= store_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Memory returns registered data after the strobe edge, so it is gated, not re-registered
    assign resp_rdata     = rdata_sel_q ? mem_read_data : '0;
    assign req_ready      = ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = err_q;
    assign resp_is_load   = is_load_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_size       = size_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign load_cnt       = load_cnt_q;
    assign store_cnt      = store_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule
